// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver feeding a first-word fall-through receive FIFO
// Optional even-parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic                          rx,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state;
  logic                   sync1, sync2;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [DATA_WIDTH-1:0]  shift;
  logic                   armed;
  logic [1:0]             settle;
  logic                   push_req;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
`endif

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic                   full, pop, push_ok;

  assign full     = (fifo_count == DEPTH_C);
  assign rx_valid = (fifo_count != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
  assign pop      = rx_valid && rx_ready && ena;
  assign push_ok  = push_req && ena && (!full || pop);

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else if (ena) begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  // Receive FSM: mid-bit sampling, character assembly, error pulses and push request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      settle    <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else if (!ena) begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // The synchronizer holds its reset value for two cycles; ignore it until real data arrives.
      if (settle != 2'd2) settle <= settle + 2'd1;
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (settle == 2'd2) begin
            if (sync2) begin
              armed <= 1'b1;
            end else if (armed) begin
              armed <= 1'b0;
              state <= S_START;
            end
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= sync2 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            shift <= DATA_WIDTH'({sync2, shift} >> 1);
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt        <= '0;
            par_bad    <= ^{shift, sync2};
            parity_err <= ^{shift, sync2};
            state      <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (!sync2) begin
              frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (!par_bad) begin
`else
            end else begin
`endif
              push_req <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and overrun pulse; a pop frees room for a same-cycle push.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_req && ena && full && !pop) overrun <= 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push_ok) fifo_count <= fifo_count - 1'b1;
    end
  end

  // FIFO storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) mem[wr_ptr] <= shift;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CPB   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ena = 1'b1;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [3:0]    fifo_count;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int perr_cnt = 0;
  int max_count = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // Pulse counters and peak occupancy, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt++;
`endif
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_bits({1'b0, stop, ^d, d, 1'b0}, 11);
`else
    send_bits({2'b00, stop, d, 1'b0}, 10);
`endif
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] d);
    send_bits({1'b0, 1'b1, ~(^d), d, 1'b0}, 11);
  endtask
`endif

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int f0;
    int o0;
    int p0;
    logic [7:0] exp_q[8];

    vecs[0] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    rx = 1'b1;
    tick(3);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_count", fifo_count, 4'd0);
    check("reset_data", rx_data, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    tick(6);

    send_frame(8'hA5, 1'b1);
    tick(1);
    check("a5_before_push_valid", rx_valid, 1'b0);
    tick(1);
    check("a5_valid", rx_valid, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_count", fifo_count, 4'd1);
    pop_one();
    check("a5_popped_count", fifo_count, 4'd0);
    tick(4);

    for (int v = 0; v < 6; v++) begin
      f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      tick(8);
      check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_push);
      check($sformatf("vec%0d_count", v), fifo_count, {3'd0, vecs[v].exp_push});
      check($sformatf("vec%0d_frame_err", v), ferr_cnt - f0, {31'd0, vecs[v].exp_ferr});
      if (vecs[v].exp_push) begin
        check($sformatf("vec%0d_data", v), rx_data, vecs[v].data);
        pop_one();
        check($sformatf("vec%0d_pop_count", v), fifo_count, 4'd0);
      end
    end

    f0 = ferr_cnt;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(12);
    check("glitch_count", fifo_count, 4'd0);
    check("glitch_frame_err", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b1);
    tick(4);
    check("after_glitch_data", rx_data, 8'h5A);
    check("after_glitch_count", fifo_count, 4'd1);

    ena = 1'b0;
    rx_ready = 1'b1;
    tick(4);
    check("ena_low_count", fifo_count, 4'd1);
    check("ena_low_data", rx_data, 8'h5A);
    ena = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("ena_high_pop_count", fifo_count, 4'd0);
    rx_ready = 1'b1;
    tick(3);
    rx_ready = 1'b0;
    check("ready_empty_count", fifo_count, 4'd0);
    check("ready_empty_valid", rx_valid, 1'b0);

    o0 = ovr_cnt;
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      tick(4);
    end
    tick(4);
    check("fill9_count", fifo_count, 4'd8);
    check("fill9_overrun", ovr_cnt - o0, 1);
    check("fill9_max_count", max_count, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill9_pop%0d", i), rx_data, 8'(i));
      pop_one();
    end
    check("fill9_drained_valid", rx_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      tick(4);
      if (i > 0) exp_q[i-1] = 8'h10 + 8'(i);
    end
    exp_q[7] = 8'h99;
    check("full_count", fifo_count, 4'd8);
    o0 = ovr_cnt;
    send_frame(8'h99, 1'b1);
    tick(1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(4);
    check("full_pushpop_count", fifo_count, 4'd8);
    check("full_pushpop_overrun", ovr_cnt - o0, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_pushpop_pop%0d", i), rx_data, exp_q[i]);
      pop_one();
    end
    check("full_pushpop_empty", fifo_count, 4'd0);

    f0 = ferr_cnt;
    rx = 1'b0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(20);
    rx = 1'b1;
    tick(10);
    check("low_line_reset_count", fifo_count, 4'd0);
    check("low_line_reset_frame_err", ferr_cnt - f0, 0);

    f0 = ferr_cnt;
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB);
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB);
    rx = 1'b0; tick(2);
    reset_n = 1'b0;
    rx = 1'b1;
    tick(2);
    check("midframe_reset_count", fifo_count, 4'd0);
    reset_n = 1'b1;
    tick(6);
    send_frame(8'h81, 1'b1);
    tick(6);
    check("midframe_reset_next_count", fifo_count, 4'd1);
    check("midframe_reset_next_data", rx_data, 8'h81);
    check("midframe_reset_frame_err", ferr_cnt - f0, 0);
    pop_one();
    check("midframe_reset_drained", fifo_count, 4'd0);

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_frame_badpar(8'h81);
    tick(6);
    check("badpar_parity_err", perr_cnt - p0, 1);
    check("badpar_count", fifo_count, 4'd0);
    p0 = perr_cnt;
    send_frame(8'h81, 1'b1);
    tick(6);
    check("goodpar_parity_err", perr_cnt - p0, 0);
    check("goodpar_data", rx_data, 8'h81);
    pop_one();
`else
    p0 = perr_cnt;
    tick(2);
    check("no_parity_err_pulses", perr_cnt - p0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
